// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback and drives
// datapath selects and enables. Define PERF_CNT_EN to add cycle_cnt / instret_cnt counters.
module multicycle_controller #(
  parameter int unsigned ALUCTRL_W = 3,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic [1:0]           result_src,
  output logic                 illegal,
  output logic [3:0]           state_o
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     instret_cnt
`endif
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10,
    StTrap     = 4'd11
  } state_e;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRtype = 7'b0110011;
  localparam logic [6:0] OpItype = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;

  state_e     r_state;
  state_e     w_state_d;
  logic       r_illegal;
  logic       w_f3_ok;
  logic       w_legal;
  logic [2:0] w_funct_alu;
  logic [2:0] w_alu;

  // ALU op from funct3; funct7b5 selects sub only for R-type
  always_comb begin
    w_f3_ok     = 1'b1;
    w_funct_alu = 3'd0;
    case (funct3)
      3'b000:  w_funct_alu = (opcode == OpRtype && funct7b5) ? 3'd1 : 3'd0;
      3'b111:  w_funct_alu = 3'd2;
      3'b110:  w_funct_alu = 3'd3;
      3'b100:  w_funct_alu = 3'd4;
      3'b010:  w_funct_alu = 3'd5;
      default: w_f3_ok     = 1'b0;
    endcase
  end

  always_comb begin
    w_legal = 1'b0;
    case (opcode)
      OpLoad, OpStore: w_legal = (funct3 == 3'b010);
      OpBeq:           w_legal = (funct3 == 3'b000);
      OpJal:           w_legal = 1'b1;
      OpItype:         w_legal = w_f3_ok;
      OpRtype:         w_legal = w_f3_ok && (!funct7b5 || funct3 == 3'b000);
      default:         w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_state_d  = r_state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    w_alu      = 3'd0;
    result_src = 2'b00;
    case (r_state)
      StFetch: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          w_state_d = StDecode;
        end
      end
      StDecode: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        if (!w_legal) begin
          w_state_d = StTrap;
        end else begin
          case (opcode)
            OpLoad, OpStore: w_state_d = StMemAdr;
            OpRtype:         w_state_d = StExecR;
            OpItype:         w_state_d = StExecI;
            OpBeq:           w_state_d = StBeq;
            default:         w_state_d = StJal;
          endcase
        end
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_state_d = opcode[5] ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) w_state_d = StMemWb;
      end
      StMemWb: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        w_state_d  = StFetch;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) w_state_d = StFetch;
      end
      StExecR: begin
        alu_src_a = 2'b10;
        w_alu     = w_funct_alu;
        w_state_d = StAluWb;
      end
      StExecI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_alu     = w_funct_alu;
        w_state_d = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        w_state_d = StFetch;
      end
      StBeq: begin
        alu_src_a = 2'b10;
        w_alu     = 3'd1;
        pc_write  = zero;
        w_state_d = StFetch;
      end
      StJal: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        w_state_d = StAluWb;
      end
      default: w_state_d = StTrap;
    endcase
    // Outputs are forced quiet combinationally while reset is held
    if (!rst_n) begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      w_alu      = 3'd0;
      result_src = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StFetch;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_illegal <= r_illegal | (w_state_d == StTrap);
    end
  end

  assign alu_control = ALUCTRL_W'(w_alu);
  assign illegal     = r_illegal;
  assign state_o     = r_state;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;
  logic             w_retire;

  assign w_retire = (w_state_d == StFetch) &&
                    (r_state inside {StMemWb, StMemWrite, StAluWb, StBeq});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (w_retire) r_instret_cnt <= r_instret_cnt + CNT_W'(1);
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: every cycle of each instruction is checked against a
// step-sequence model built from the instruction rules, with directed and random stimulus.
`timescale 1ns/1ps
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_read, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] alu_control;
  logic [3:0] state_o;
  logic [14:0] obs;
  int total = 0;
  int bad = 0;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
  int unsigned m_cycles = 0;
  int unsigned m_instret = 0;
`endif

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef enum int {SFetch, SDecode, SMemAdr, SMemRead, SMemWb, SMemWrite,
                    SExecR, SExecI, SAluWb, SBeq, SJal, STrap} step_e;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .result_src(result_src), .illegal(illegal), .state_o(state_o)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign obs = {mem_read, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, alu_control, result_src};

`ifdef PERF_CNT_EN
  always @(posedge clk) begin
    if (!rst_n) m_cycles = 0;
    else m_cycles = m_cycles + 1;
  end
`endif

  function automatic bit legal(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    bit alu_f3;
    alu_f3 = (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd6) || (f3 == 3'd7);
    if (o == OP_LW || o == OP_SW) return f3 == 3'd2;
    if (o == OP_BEQ) return f3 == 3'd0;
    if (o == OP_JAL) return 1'b1;
    if (o == OP_I) return alu_f3;
    if (o == OP_R) return alu_f3 && (!f7 || f3 == 3'd0);
    return 1'b0;
  endfunction

  function automatic logic [2:0] alu_code(input bit is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (is_r && f7) ? 3'd1 : 3'd0;
      3'd7:    return 3'd2;
      3'd6:    return 3'd3;
      3'd4:    return 3'd4;
      3'd2:    return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  // {mem_read, mem_write, adr_src, ir_write, pc_write, reg_write, A, B, alu, result_src}
  function automatic logic [14:0] expect_out(input step_e s, input logic mr, input logic z,
                                             input logic [2:0] ac);
    logic rd, wr, adr, irw, pcw, rgw;
    logic [1:0] a, b, rs;
    logic [2:0] alu;
    {rd, wr, adr, irw, pcw, rgw} = 6'b0;
    a = 2'd0; b = 2'd0; rs = 2'd0; alu = 3'd0;
    case (s)
      SFetch:    begin rd = 1'b1; b = 2'd2; rs = 2'd2; irw = mr; pcw = mr; end
      SDecode:   begin a = 2'd1; b = 2'd1; end
      SMemAdr:   begin a = 2'd2; b = 2'd1; end
      SMemRead:  begin adr = 1'b1; rd = 1'b1; end
      SMemWb:    begin rs = 2'd1; rgw = 1'b1; end
      SMemWrite: begin adr = 1'b1; wr = 1'b1; end
      SExecR:    begin a = 2'd2; alu = ac; end
      SExecI:    begin a = 2'd2; b = 2'd1; alu = ac; end
      SAluWb:    rgw = 1'b1;
      SBeq:      begin a = 2'd2; alu = 3'd1; pcw = z; end
      SJal:      begin a = 2'd1; b = 2'd2; pcw = 1'b1; end
      default:   ;
    endcase
    return {rd, wr, adr, irw, pcw, rgw, a, b, alu, rs};
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Enters at posedge+1 (or earlier), leaves at posedge+1 with the DUT in FETCH.
  task automatic do_reset();
    mem_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_outputs", 32'(obs), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
`ifdef PERF_CNT_EN
    check("rst_cycle_cnt", cycle_cnt, 32'd0);
    check("rst_instret_cnt", instret_cnt, 32'd0);
    m_instret = 0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int f_stall, input int m_stall,
                           input int abort_at, input int trap_cycles);
    step_e path[$];
    bit ok;
    bit wait_step;
    int stall;
    logic [2:0] ac;
    ok = legal(o, f3, f7);
    ac = alu_code(o == OP_R, f3, f7);
    path.push_back(SFetch);
    path.push_back(SDecode);
    if (!ok) path.push_back(STrap);
    else if (o == OP_LW) begin path.push_back(SMemAdr); path.push_back(SMemRead);
                               path.push_back(SMemWb); end
    else if (o == OP_SW) begin path.push_back(SMemAdr); path.push_back(SMemWrite); end
    else if (o == OP_R) begin path.push_back(SExecR); path.push_back(SAluWb); end
    else if (o == OP_I) begin path.push_back(SExecI); path.push_back(SAluWb); end
    else if (o == OP_BEQ) path.push_back(SBeq);
    else begin path.push_back(SJal); path.push_back(SAluWb); end
    opcode = o; funct3 = f3; funct7b5 = f7; zero = z;
    foreach (path[i]) begin
      if (path[i] == STrap) begin
        repeat (trap_cycles) begin
          mem_ready = 1'($urandom);
          #1;
          check("trap_outputs", 32'(obs), 32'd0);
          check("trap_illegal", 32'(illegal), 32'd1);
          @(posedge clk);
          #1;
        end
      end else begin
        wait_step = (path[i] == SFetch) || (path[i] == SMemRead) || (path[i] == SMemWrite);
        stall = (path[i] == SFetch) ? f_stall : (wait_step ? m_stall : 0);
        for (int c = 0; c <= stall; c++) begin
          mem_ready = wait_step ? (c == stall) : 1'($urandom);
          #1;
          check(path[i].name(), 32'(obs), 32'(expect_out(path[i], mem_ready, z, ac)));
          check("no_illegal", 32'(illegal), 32'd0);
          if (i == abort_at) begin
            do_reset();
            return;
          end
          @(posedge clk);
          #1;
        end
      end
    end
    if (!ok) begin
      do_reset();
    end else begin
`ifdef PERF_CNT_EN
      m_instret++;
      check("cycle_cnt", cycle_cnt, m_cycles);
      check("instret_cnt", instret_cnt, m_instret);
`endif
    end
  endtask

  initial begin
    logic [6:0] o;
    logic [2:0] f3;
    do_reset();
    // add, lw with 2 wait states, beq taken / not taken, jal, stalled sw
    run_instr(OP_R,   3'd0, 1'b0, 1'b0, 0, 0, -1, 0);
    run_instr(OP_LW,  3'd2, 1'b0, 1'b0, 0, 2, -1, 0);
    run_instr(OP_BEQ, 3'd0, 1'b0, 1'b1, 0, 0, -1, 0);
    run_instr(OP_BEQ, 3'd0, 1'b0, 1'b0, 0, 0, -1, 0);
    run_instr(OP_JAL, 3'd5, 1'b1, 1'b0, 0, 0, -1, 0);
    run_instr(OP_SW,  3'd2, 1'b0, 1'b0, 1, 1, -1, 0);
    // Remaining ALU ops; I-type ignores funct7b5
    run_instr(OP_R,   3'd0, 1'b1, 1'b0, 0, 0, -1, 0);
    run_instr(OP_R,   3'd7, 1'b0, 1'b0, 0, 0, -1, 0);
    run_instr(OP_R,   3'd6, 1'b0, 1'b0, 0, 0, -1, 0);
    run_instr(OP_I,   3'd4, 1'b0, 1'b0, 0, 0, -1, 0);
    run_instr(OP_I,   3'd2, 1'b0, 1'b0, 0, 0, -1, 0);
    run_instr(OP_I,   3'd0, 1'b1, 1'b0, 0, 0, -1, 0);
    // Illegal: lui, R-type with funct7b5 on and, lw with wrong funct3
    run_instr(OP_LUI, 3'd0, 1'b0, 1'b0, 0, 0, -1, 10);
    run_instr(OP_R,   3'd7, 1'b1, 1'b0, 0, 0, -1, 3);
    run_instr(OP_LW,  3'd0, 1'b0, 1'b0, 0, 0, -1, 3);
    run_instr(OP_I,   3'd1, 1'b0, 1'b0, 0, 0, -1, 3);
    // Reset mid-MEMWRITE, then a clean instruction must follow
    run_instr(OP_SW,  3'd2, 1'b0, 1'b0, 0, 4, 3, 0);
    run_instr(OP_I,   3'd0, 1'b0, 1'b0, 0, 0, -1, 0);
    run_instr(OP_I,   3'd0, 1'b0, 1'b0, 0, 0, -1, 0);
    run_instr(OP_I,   3'd0, 1'b0, 1'b0, 0, 0, -1, 0);
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0: o = OP_LW;
        1: o = OP_SW;
        2: o = OP_R;
        3: o = OP_I;
        4: o = OP_BEQ;
        5: o = OP_JAL;
        6: o = OP_LUI;
        default: o = 7'($urandom);
      endcase
      f3 = 3'($urandom);
      if ((o == OP_LW || o == OP_SW) && $urandom_range(0, 3) != 0) f3 = 3'd2;
      if (o == OP_BEQ && $urandom_range(0, 3) != 0) f3 = 3'd0;
      run_instr(o, f3, 1'($urandom_range(0, 3) == 0), 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2), -1, 3);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
